// File: rtl/signed_bisect_ctrl_pkg.sv
// Shared types and constants for the signed binary-search controller.
package bisect_pkg;

  localparam int WIDTH = 8;
  localparam int ITER_W = 4;

  // Search bounds are held one bit wider than the operand so that
  // probe+1 / probe-1 at the extremes never wrap.
  localparam logic signed [WIDTH:0] LO_INIT = -9'sd128;
  localparam logic signed [WIDTH:0] HI_INIT = 9'sd127;

  // Nine probes always cover 256 values.
  localparam logic [ITER_W-1:0] MAX_ITER = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    EVAL,
    DONE
  } state_t;

  // Floor midpoint of two in-range bounds. The sum of two values in
  // -128..127 always fits the widened 9-bit signed format.
  function automatic logic signed [WIDTH:0] midpoint(
    input logic signed [WIDTH:0] a,
    input logic signed [WIDTH:0] b
  );
    logic signed [WIDTH:0] sum;
    sum = a + b;
    return sum >>> 1;
  endfunction

endpackage

// File: rtl/signed_bisect_ctrl.sv
// Signed binary-search initiator for an 8-bit COMPARE block: drives the
// B operand, samples the gt/eq/lt flags and converges on the A operand.
module signed_bisect_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    cmp_gt,
  input  logic                    cmp_eq,
  input  logic                    cmp_lt,
  output logic signed [WIDTH-1:0] probe,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    found,
  output logic                    error,
  output logic [3:0]              iter_cnt
);
  import bisect_pkg::*;

  localparam int SW = WIDTH + 1;
  // Last value of the settle counter before the flags are sampled.
  localparam logic [2:0] SETTLE_LAST = (SETTLE == 0) ? 3'd0 : 3'(SETTLE - 1);

  state_t state, state_next;

  logic signed [SW-1:0]    lo, hi, lo_next, hi_next;
  logic signed [SW-1:0]    mid, probe_ext, lo_up, hi_dn;
  logic signed [WIDTH-1:0] probe_next, result_next;
  logic                    found_next, error_next, busy_next, done_next;
  logic [3:0]              iter_next;
  logic [2:0]              settle_cnt, settle_next;
  logic [2:0]              flags;

  assign probe_ext = {probe[WIDTH-1], probe};
  assign mid       = midpoint(lo, hi);
  assign lo_up     = probe_ext + SW'(1);
  assign hi_dn     = probe_ext - SW'(1);
  assign flags     = {cmp_gt, cmp_eq, cmp_lt};

  // Next-state and next-register computation; abort overrides everything.
  always_comb begin
    state_next  = state;
    lo_next     = lo;
    hi_next     = hi;
    probe_next  = probe;
    result_next = result;
    found_next  = found;
    error_next  = error;
    iter_next   = iter_cnt;
    busy_next   = busy;
    done_next   = 1'b0;
    settle_next = settle_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = SETUP;
          found_next = 1'b0;
          error_next = 1'b0;
          iter_next  = 4'd0;
          lo_next    = LO_INIT;
          hi_next    = HI_INIT;
          busy_next  = 1'b1;
        end
      end

      SETUP: begin
        if (iter_cnt == MAX_ITER) begin
          // Unreachable with a consistent responder; a hard stop anyway.
          error_next  = 1'b1;
          result_next = probe;
          state_next  = DONE;
        end else begin
          probe_next  = mid[WIDTH-1:0];
          iter_next   = iter_cnt + 4'd1;
          settle_next = 3'd0;
          state_next  = (SETTLE == 0) ? EVAL : WAIT;
        end
      end

      WAIT: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = EVAL;
        end else begin
          settle_next = settle_cnt + 3'd1;
        end
      end

      EVAL: begin
        case (flags)
          3'b010: begin
            result_next = probe;
            found_next  = 1'b1;
            state_next  = DONE;
          end
          3'b100: begin
            lo_next = lo_up;
            if (lo_up > hi) begin
              error_next  = 1'b1;
              result_next = probe;
              state_next  = DONE;
            end else begin
              state_next = SETUP;
            end
          end
          3'b001: begin
            hi_next = hi_dn;
            if (lo > hi_dn) begin
              error_next  = 1'b1;
              result_next = probe;
              state_next  = DONE;
            end else begin
              state_next = SETUP;
            end
          end
          default: begin
            error_next  = 1'b1;
            result_next = probe;
            state_next  = DONE;
          end
        endcase
      end

      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase

    if (abort) begin
      state_next = IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Search bounds, probe, settle counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo         <= LO_INIT;
      hi         <= HI_INIT;
      probe      <= '0;
      result     <= '0;
      found      <= 1'b0;
      error      <= 1'b0;
      iter_cnt   <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= 3'd0;
    end else begin
      lo         <= lo_next;
      hi         <= hi_next;
      probe      <= probe_next;
      result     <= result_next;
      found      <= found_next;
      error      <= error_next;
      iter_cnt   <= iter_next;
      busy       <= busy_next;
      done       <= done_next;
      settle_cnt <= settle_next;
    end
  end

endmodule
